// File: rtl/sum_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO through a valid/ready handshake.
// A queued byte is popped straight into the next start bit, so back-to-back frames leave no idle gap.
module sum_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [1:0]    state;
    logic [7:0]    shift;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          full, empty, push, pop, bit_end;
    logic [7:0]    head;

    // Extra pointer bit makes the difference range 0..FIFO_DEPTH, so full and empty stay distinct.
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign empty      = (fifo_level == '0);
    assign in_ready   = !full && !reset;
    assign push       = in_valid && in_ready;
    assign bit_end    = (cnt == '0);
    assign pop        = !empty && ((state == IDLE) || (state == STOP && bit_end));
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // tx/busy are set on the transition into each state so the line is register-driven.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else if (state == IDLE) begin
            if (pop) begin
                shift <= head;
                cnt   <= CNT_LOAD;
                state <= START;
                tx    <= 1'b0;
                busy  <= 1'b1;
            end
        end else if (!bit_end) begin
            cnt <= cnt - 1'b1;
        end else begin
            cnt <= CNT_LOAD;
            case (state)
                START: begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shift[0];
                end
                DATA: begin
                    if (idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        shift <= shift >> 1;
                        idx   <= idx + 1'b1;
                        tx    <= shift[1];
                    end
                end
                STOP: begin
                    if (!empty) begin
                        shift <= head;
                        state <= START;
                        tx    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Byte-stream UART transmitter that serialises result bytes from the core datapath onto one bidirectional pad. The top level pushes each registered 8-bit result through a valid/ready handshake. The top level drives `uio_out[0] = tx` and `uio_oe[0] = 1`. A small FIFO absorbs bursts, and the transmitter emits standard 8N1 frames at a fixed clocks-per-bit rate.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.

- `clock` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: producer has a byte on `in_data`.
- `in_ready` output 1: FIFO can accept a byte.
- `in_data` input 8: byte to transmit.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte in flight.

## Operation
- Accept rule: a byte is written on a rising edge where `in_valid && in_ready`.
- `in_ready = !full`, and `in_ready` is forced 0 while `reset` is asserted.
- Full FIFO: a push is rejected even if a pop occurs on the same edge. There is no full-bypass.
- Empty FIFO: pop and push on the same edge are both legal and `fifo_level` stays correct.
- Pointers wrap modulo FIFO_DEPTH. An extra level bit distinguishes full from empty.
- `in_data` is ignored when the byte is not accepted. `in_data` must be stable only on the accept edge.
- Frame format: start bit (0), then data bits 0..7 LSB first, then one stop bit (1). Each bit is held exactly CLK_DIV cycles, giving 10×CLK_DIV cycles per frame.
- The FSM has states IDLE, START, DATA, STOP.
- IDLE: `tx`=1 and `busy`=0. If the FIFO is non-empty, pop into the shift register and go to START.
- START: hold `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift[0] for CLK_DIV cycles, then shift right and increment the index. After bit 7, go to STOP.
- STOP: hold `tx`=1 for CLK_DIV cycles.
- At the last STOP cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- `busy`=1 in START, DATA and STOP.
- The bit-timer counter is $clog2(CLK_DIV) bits wide. It reloads at every bit boundary.
- The bit index is 3 bits wide.
- `tx` and `busy` are registered outputs, so they never glitch.
- Reset state: `tx`=1, `busy`=0, `fifo_level`=0, `in_ready`=0 while reset is held, FSM = IDLE, pointers = 0.
- Reset mid-frame: the frame is aborted and `tx` returns to 1 asynchronously. The FIFO contents are discarded. No partial frame resumes after release.

## Timing
- Acceptance to start bit is 2 edges when idle and the FIFO is empty. The push occurs at edge N and the pop at edge N+1. `tx` falls after edge N+1.
- A popped byte leaves `fifo_level` on the pop edge.
- `tx` low lasts exactly CLK_DIV cycles. Each data bit lasts exactly CLK_DIV cycles.
- `busy` is high for exactly 10×CLK_DIV cycles per frame. With back-to-back frames it stays high continuously.
- The first accept is possible on the first rising edge after reset deassertion.

## Test plan
- Reset: hold `reset` for 3 cycles, then release. Required: `tx`=1, `busy`=0, `fifo_level`=0 throughout reset; `in_ready`=0 during reset and 1 from the first cycle after release.
- Single byte, CLK_DIV=4, 0xA5 pushed at edge 0:
  - `tx` is low for cycles 2–5.
  - Data bits are 1,0,1,0,0,1,0,1, each bit 4 cycles.
  - Stop bit is high for 4 cycles.
  - `busy` is high for exactly 40 cycles, then `tx` idles at 1.
- Back-to-back, CLK_DIV=4: push 0x00 then 0xFF on consecutive edges. Required:
  - The second start bit begins on the cycle immediately after the first stop bit.
  - `busy` is high continuously for 80 cycles.
  - The line pattern is 0, eight 0s, 1, 0, eight 1s, 1.
- FIFO full, FIFO_DEPTH=4: hold `in_valid` for 6 consecutive edges with data 0x10..0x15 while idle. Required:
  - 0x10 pops at the edge after its push.
  - 0x11..0x14 fill the FIFO (`fifo_level`=4) and `in_ready` drops.
  - 0x15 is accepted only after the 0x10 frame ends.
  - The line output order is 0x10..0x15.
- Stall: with the FIFO full, toggle `in_data` while `in_valid`=1 and `in_ready`=0. Required: none of the toggled values is ever transmitted, and `fifo_level` stays 4.
- Reset mid-frame: assert `reset` during data bit 3 of 0x3C with 2 bytes queued. Required:
  - `tx`=1 immediately (asynchronous), `busy`=0, `fifo_level`=0.
  - After release, `tx` stays 1 with no further frames.
